// File: rtl/kernel_pkg.sv
// Types and constants shared by the kernel window loader and the ALU cache port.
// Combinational only: no latency, no flow control.
package kernel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    COMMIT
  } loader_state_t;

  localparam int NUM_KLINES = 3;
  localparam int KWORD_W    = 24;

endpackage

// File: rtl/kernel_cache_loader.sv
// Fetches a 3-row convolution window over req/gnt/rvalid and commits it atomically to the ALU cache.
// Latency 7 cycles from start with no memory stalls; one request outstanding, stalls on gnt/rvalid, busy back-pressures decode.
module kernel_cache_loader
  import kernel_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WORD_W = KWORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] cache_out [0:NUM_KLINES-1],
  output logic              cache_valid,
  output logic              busy,
  output logic              load_done
);

  loader_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [1:0]        idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              shadow_we;
  logic              commit;
  logic [WORD_W-1:0] shadow_q [0:NUM_KLINES-1];
  logic [WORD_W-1:0] cache_q  [0:NUM_KLINES-1];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    idx_d     = idx_q;
    shadow_we = 1'b0;
    commit    = 1'b0;
    valid_d   = valid_q & ~flush;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          addr_d   = base_addr;
          stride_d = stride;
          idx_d    = 2'd0;
          state_d  = REQ;
        end
      end
      REQ: begin
        // An accepted request must have its response drained even if flushed.
        if (mem_gnt) begin
          addr_d  = addr_q + stride_q;
          state_d = flush ? DRAIN : WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            shadow_we = 1'b1;
            if (idx_q == 2'd2) begin
              state_d = COMMIT;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = REQ;
            end
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rvalid) state_d = IDLE;
      end
      COMMIT: begin
        state_d = IDLE;
        if (!flush) begin
          commit  = 1'b1;
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= 2'd0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_KLINES; i++) begin
        shadow_q[i] <= '0;
        cache_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      if (shadow_we) shadow_q[idx_q] <= mem_rdata;
      if (commit) begin
        for (int i = 0; i < NUM_KLINES; i++) cache_q[i] <= shadow_q[i];
      end
    end
  end

  assign mem_req     = (state_q == REQ);
  assign mem_addr    = addr_q;
  assign busy        = (state_q != IDLE);
  assign cache_valid = valid_q;
  assign load_done   = done_q;
  assign cache_out   = cache_q;

endmodule

// File: doc/kernel_cache_loader.md
Name: kernel_cache_loader

Overview:
- Upstream feeder for the execute-stage ALU's kernel path.
- Fetches three 24-bit words (one convolution window: rows at base, base+stride, base+2*stride) from data memory over a req/gnt/rvalid port.
- Double-buffers the words and presents them as the 3-entry cache array the ALU's kernel unit consumes.
- Raises busy so decode can stall kernel instructions until the window is valid.

Parameters:
- ADDR_W, 16, width of memory addresses and stride.
- WORD_W, 24, width of one cache entry; must match the ALU cache entry width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request from decode; sampled only in IDLE.
- flush  in  1  invalidate cache, abort any load in progress.
- base_addr  in  ADDR_W  address of entry 0; latched on accepted start.
- stride  in  ADDR_W  address step between entries; latched on accepted start.
- mem_req  out  1  read request to data memory.
- mem_addr  out  ADDR_W  read address; valid while mem_req=1.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read data valid this cycle.
- mem_rdata  in  WORD_W  read data.
- cache_out  out  WORD_W x3 (unpacked [0:2])  committed window, to ALU cache input.
- cache_valid  out  1  cache_out holds a complete committed window.
- busy  out  1  load in progress or draining; decode must stall kernel ops.
- load_done  out  1  one-cycle pulse when a new window commits.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; cache_out, shadow regs, idx, addr_reg all 0.
  - cache_valid, busy, mem_req and load_done all 0.
- Registers:
  - addr_reg: current request address.
  - idx: 2 bits, 0..2.
  - shadow[0:2]: fill buffer.
  - cache_out: updated only in COMMIT, so the ALU sees a stable old window throughout a load.
- FSM states: IDLE, REQ, WAIT, DRAIN, COMMIT.
- IDLE:
  - start=1 and flush=0 -> latch addr_reg=base_addr and stride, idx=0, go to REQ.
  - start is ignored in every other state; decode must honour busy.
- REQ:
  - mem_req=1, mem_addr=addr_reg.
  - mem_gnt=1 -> addr_reg += stride (mod 2^ADDR_W, wrap silently), go to WAIT.
  - mem_rvalid in REQ is ignored.
- WAIT:
  - mem_req=0; wait for mem_rvalid; only one request outstanding at any time.
  - On rvalid: shadow[idx]=mem_rdata.
  - idx==2 -> go to COMMIT; else idx++ and go to REQ.
- COMMIT (one cycle):
  - cache_out=shadow, cache_valid=1, load_done=1 for the following cycle, go to IDLE.
- busy=1 in REQ, WAIT, DRAIN and COMMIT; busy=0 only in IDLE.
- Minimum latency, with gnt in the first REQ cycle and rvalid the next cycle:
  - start sampled at edge 0; cache_valid=1 and load_done=1 after edge 7.
  - Each extra gnt or rvalid wait cycle adds one cycle.
- flush (synchronous, highest priority):
  - Always clears cache_valid at the next edge. cache_out contents are retained but invalid.
  - IDLE: stay in IDLE; a simultaneous start is dropped.
  - REQ with mem_gnt=0 -> IDLE; request withdrawn.
  - REQ with mem_gnt=1 -> DRAIN; request already accepted.
  - WAIT with mem_rvalid=0 -> DRAIN.
  - WAIT with mem_rvalid=1 -> IDLE; data discarded.
  - DRAIN: wait for mem_rvalid, discard the data, go to IDLE. flush in DRAIN has no further effect.
  - COMMIT -> IDLE with no commit; cache_valid stays 0 and load_done is not pulsed.
- A reload while cache_valid=1 keeps cache_valid=1 and the old cache_out until the new COMMIT.
- Reset mid-load: immediate return to reset values; any outstanding memory response after reset is ignored (IDLE ignores rvalid).
- stride=0 is legal; all three entries are read from the same address.

Decomposition:
- Shared package kernel_pkg holds:
  - loader_state_t enum {IDLE, REQ, WAIT, DRAIN, COMMIT}.
  - NUM_KLINES=3 and KWORD_W=24, the constants shared with the ALU cache port.
- Single module, no sub-module: the address step, shadow buffer and FSM are too small to split.

Test Plan:
1. Reset, then start with base=0x0100, stride=0x0040; memory grants immediately and returns 0xAAAAAA, 0xBBBBBB, 0xCCCCCC one cycle later -> mem_addr 0x0100, 0x0140, 0x0180; cache_out={AAAAAA,BBBBBB,CCCCCC}; cache_valid and load_done rise 7 cycles after start; busy falls the same cycle.
2. gnt delayed 3 cycles and rvalid delayed 2 cycles per word -> mem_req/mem_addr held stable until gnt; latency 7+15=22 cycles; same data committed.
3. Reload while valid: base=0x0200, new data 0x111111, 0x222222, 0x333333 -> old window stays on cache_out with cache_valid=1 until the new COMMIT, then swaps in one cycle.
4. base=0xFFF0, stride=0x0010 -> mem_addr 0xFFF0, 0x0000, 0x0010 (wrap).
5. flush in WAIT for word 1 with rvalid 2 cycles later -> state DRAIN; stale data not written; cache_valid=0; busy falls the cycle after rvalid; a following start loads correctly.
6. start and flush in the same IDLE cycle -> no mem_req, cache_valid=0; rst_n low mid-REQ -> outputs 0 immediately; a late rvalid after reset is ignored.
